// File: rtl/expr_pipe_eval_if.sv
// expr_pipe_eval_if: beat handshake plus packed per-lane operands and results.
interface expr_pipe_eval_if #(
    parameter int W = 6,
    parameter int LANES = 3
);
    logic in_valid, in_ready, sgn, acc, acc_clr, out_valid, out_ready;
    logic [2:0] op;
    logic [LANES*W-1:0] a, b, y;
    logic [LANES-1:0] dz;
    modport master (
        output in_valid, op, sgn, acc, acc_clr, a, b, out_ready,
        input in_ready, out_valid, y, dz
    );
    modport slave (
        input in_valid, op, sgn, acc, acc_clr, a, b, out_ready,
        output in_ready, out_valid, y, dz
    );
endinterface

// File: rtl/expr_pipe_eval.sv
// expr_pipe_eval: multi-lane ALU with per-lane accumulators; results formed in stage 1,
// then carried through a stall-able delay pipeline of PIPE stages.
module expr_pipe_eval #(
    parameter int W = 6,
    parameter int LANES = 3,
    parameter int PIPE = 2
) (
    input logic clk,
    input logic rst,
    expr_pipe_eval_if.slave bus
);
    localparam int LW = LANES * W;
    logic w_adv;
    logic [LW-1:0] w_y, w_acc_nxt, r_acc;
    logic [LANES-1:0] w_dz;
    logic [PIPE:1] r_v;
    logic [LW-1:0] r_y [1:PIPE];
    logic [LANES-1:0] r_dz [1:PIPE];

    assign w_adv = !r_v[PIPE] || bus.out_ready;
    assign bus.in_ready = w_adv;
    assign bus.out_valid = r_v[PIPE];
    assign bus.y = r_y[PIPE];
    assign bus.dz = r_dz[PIPE];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [W-1:0] w_a, w_b, w_q, w_m, w_sr, w_op, w_base, w_res;
        logic signed [W:0] w_sa, w_sb;
        logic w_z, w_ge;
        assign w_a = bus.a[i*W +: W];
        assign w_b = bus.b[i*W +: W];
        // One extra bit keeps MIN / -1 representable; truncation wraps it back to MIN
        assign w_sa = {bus.sgn & w_a[W-1], w_a};
        assign w_sb = {bus.sgn & w_b[W-1], w_b};
        assign w_q = W'(w_sa / w_sb);
        assign w_m = W'(w_sa % w_sb);
        assign w_sr = $signed(w_a) >>> w_b;
        assign w_z = w_b == '0;
        assign w_ge = bus.sgn ? ($signed(w_a) >= $signed(w_b)) : (w_a >= w_b);
        always_comb begin
            w_op = '0;
            case (bus.op)
                3'd0: w_op = w_a + w_b;
                3'd1: w_op = w_a - w_b;
                3'd2: w_op = w_a * w_b;
                3'd3: w_op = w_z ? '1 : w_q;
                3'd4: w_op = w_z ? w_a : w_m;
                3'd5: w_op = int'(w_b) >= W ? '0 : w_a << w_b;
                3'd6: w_op = int'(w_b) >= W ? {W{bus.sgn & w_a[W-1]}} : bus.sgn ? w_sr : w_a >> w_b;
                default: w_op = {{(W-1){1'b0}}, w_ge};
            endcase
        end
        assign w_base = bus.acc_clr ? '0 : r_acc[i*W +: W];
        assign w_res = bus.acc ? w_base + w_op : w_op;
        assign w_y[i*W +: W] = w_res;
        assign w_dz[i] = w_z && (bus.op == 3'd3 || bus.op == 3'd4);
        assign w_acc_nxt[i*W +: W] = bus.acc ? w_res : w_base;
    end

    // Data registers load only behind a valid bit so bubbles never disturb y/dz
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
            r_acc <= '0;
            for (int k = 1; k <= PIPE; k++) begin
                r_y[k] <= '0;
                r_dz[k] <= '0;
            end
        end else if (w_adv) begin
            r_v[1] <= bus.in_valid;
            if (bus.in_valid) begin
                r_y[1] <= w_y;
                r_dz[1] <= w_dz;
                r_acc <= w_acc_nxt;
            end
            for (int k = 2; k <= PIPE; k++) begin
                r_v[k] <= r_v[k-1];
                if (r_v[k-1]) begin
                    r_y[k] <= r_y[k-1];
                    r_dz[k] <= r_dz[k-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_expr_pipe_eval.sv
// tb_expr_pipe_eval: directed and randomized checks of expr_pipe_eval against an
// integer-arithmetic reference model with a result scoreboard.
module tb_expr_pipe_eval;
    localparam int W = 6, LANES = 3, PIPE = 2, LW = W * LANES, MASK = (1 << W) - 1;
    logic clk = 0, rst = 1;
    int n_tests = 0, n_fail = 0, n_acc = 0;
    int m_acc [LANES];
    logic [LW-1:0] qy [$];
    logic [LANES-1:0] qd [$];
    logic [LW-1:0] py, ry;
    logic [LANES-1:0] pd, rdz;
    bit done;

    expr_pipe_eval_if #(.W(W), .LANES(LANES)) bus ();
    expr_pipe_eval #(.W(W), .LANES(LANES), .PIPE(PIPE)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, want);
        end
    endtask

    function automatic int sv(input int v, input bit s);
        return (s && v >= (1 << (W - 1))) ? v - (1 << W) : v;
    endfunction

    function automatic void lane_op(input int op, input bit s, input int a, input int b,
                                    output int r, output bit z);
        int x, y;
        x = sv(a, s);
        y = sv(b, s);
        z = 0;
        r = 0;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a * b;
            3: if (b == 0) begin z = 1; r = -1; end else r = x / y;
            4: if (b == 0) begin z = 1; r = a; end else r = x % y;
            5: r = (b >= W) ? 0 : a << b;
            6: r = (b >= W) ? (x < 0 ? -1 : 0) : x >>> b;
            default: r = (x >= y) ? 1 : 0;
        endcase
        r = r & MASK;
    endfunction

    function automatic void push_beat();
        logic [LW-1:0] ey;
        logic [LANES-1:0] ed;
        int r, base;
        bit z;
        ey = '0;
        ed = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_op(int'(bus.op), bus.sgn, int'(bus.a[l*W +: W]), int'(bus.b[l*W +: W]), r, z);
            base = bus.acc_clr ? 0 : m_acc[l];
            if (bus.acc) begin
                r = (base + r) & MASK;
                m_acc[l] = r;
            end else m_acc[l] = base;
            ey[l*W +: W] = W'(r);
            ed[l] = z;
        end
        qy.push_back(ey);
        qd.push_back(ed);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            qy.delete();
            qd.delete();
            foreach (m_acc[l]) m_acc[l] = 0;
        end else begin
            if (!bus.out_valid) begin
                chk("hold_y", bus.y, py);
                chk("hold_dz", bus.dz, pd);
            end else if (bus.out_ready) begin
                if (qy.size() == 0) chk("spurious_out", 1, 0);
                else begin
                    chk("y", bus.y, qy.pop_front());
                    chk("dz", bus.dz, qd.pop_front());
                end
            end
            chk("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (bus.in_valid && bus.in_ready) begin
                push_beat();
                n_acc++;
            end
        end
        py = bus.y;
        pd = bus.dz;
    end

    function automatic logic [LW-1:0] rep(input logic [W-1:0] v);
        return {LANES{v}};
    endfunction

    task automatic send(input logic [2:0] o, input logic s, input logic ac, input logic cl,
                        input logic [LW-1:0] av, input logic [LW-1:0] bv);
        int n;
        n = 0;
        bus.op = o; bus.sgn = s; bus.acc = ac; bus.acc_clr = cl; bus.a = av; bus.b = bv;
        bus.in_valid = 1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 200);
        if (!bus.in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1 bus.in_valid = 0;
    endtask

    task automatic run1(input logic [2:0] o, input logic s, input logic ac, input logic cl,
                        input logic [LW-1:0] av, input logic [LW-1:0] bv);
        int n;
        n = 0;
        send(o, s, ac, cl, av, bv);
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        chk("out_timeout", bus.out_valid, 1);
        ry = bus.y;
        rdz = bus.dz;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r, base;
        bit z;
        logic [2:0] o;
        logic [LW-1:0] av, bv;
        bus.in_valid = 0; bus.op = 0; bus.sgn = 0; bus.acc = 0; bus.acc_clr = 0;
        bus.a = 0; bus.b = 0; bus.out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_y", bus.y, 0);
        chk("rst_dz", bus.dz, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        rst = 0;
        chk("post_rst_in_ready", bus.in_ready, 1);
        lane_op(3, 1, 'h34, 'h05, r, z); chk("model_div", r, 'h3E);
        lane_op(4, 1, 'h39, 'h02, r, z); chk("model_mod", r, 'h3F);
        lane_op(6, 1, 'h30, 'h09, r, z); chk("model_shr", r, 'h3F);
        lane_op(3, 1, 'h20, 'h3F, r, z); chk("model_min_div", r, 'h20);

        for (int k = 1; k <= 3; k++) begin
            run1(0, 0, 1, 0, rep(6'd5), '0);
            chk("acc_sum", ry[W-1:0], 5 * k);
        end
        run1(0, 0, 1, 1, rep(6'd5), '0);
        chk("acc_clr", ry[W-1:0], 5);

        send(3, 1, 0, 0, rep(6'h34), rep(6'h05));
        @(negedge clk); chk("lat_early", bus.out_valid, 0);
        @(negedge clk); chk("lat_valid", bus.out_valid, 1);
        chk("div_neg", bus.y[W-1:0], 'h3E);
        chk("div_dz0", bus.dz[0], 0);
        @(posedge clk);
        #1;

        run1(3, 0, 0, 0, rep(6'h11), {6'h01, 6'h00, 6'h01});
        chk("div0_y", ry[W +: W], 'h3F); chk("div0_dz", rdz[1], 1); chk("div_ok_dz", rdz[0], 0);
        run1(4, 0, 0, 0, rep(6'h11), {6'h00, 6'h03, 6'h03});
        chk("mod0_y", ry[2*W +: W], 'h11); chk("mod0_dz", rdz[2], 1);
        run1(6, 1, 0, 0, rep(6'h30), rep(6'd2)); chk("sra", ry[W-1:0], 'h3C);
        run1(6, 0, 0, 0, rep(6'h30), rep(6'd2)); chk("srl", ry[W-1:0], 'h0C);
        run1(6, 1, 0, 0, rep(6'h30), rep(6'd9)); chk("sra_big", ry[W-1:0], 'h3F);
        run1(5, 0, 0, 0, rep(6'h3F), rep(6'd6)); chk("shl_big", ry[W-1:0], 0);
        run1(3, 1, 0, 0, rep(6'h20), rep(6'h3F)); chk("min_div", ry[W-1:0], 'h20); chk("min_div_dz", rdz, 0);
        run1(7, 1, 0, 0, rep(6'h3F), rep(6'h01)); chk("ge_signed", ry[W-1:0], 0);
        run1(7, 0, 0, 0, rep(6'h3F), rep(6'h01)); chk("ge_unsigned", ry[W-1:0], 1);
        run1(2, 1, 0, 0, rep(6'd9), rep(6'd9)); chk("mul_low", ry[W-1:0], 'h11);

        bus.out_ready = 0;
        base = n_acc;
        fork
            for (int k = 1; k <= 4; k++) send(0, 0, 0, 0, rep(W'(k)), '0);
            begin
                repeat (6) @(negedge clk);
                chk("stall_accepted", n_acc - base, 2);
                chk("stall_in_ready", bus.in_ready, 0);
                @(posedge clk);
                #1 bus.out_ready = 1;
                for (int k = 1; k <= 4; k++) begin
                    @(negedge clk);
                    chk("drain_valid", bus.out_valid, 1);
                    chk("drain_order", bus.y[W-1:0], k);
                end
            end
        join
        repeat (3) @(posedge clk);
        #1;

        send(0, 0, 1, 0, rep(6'd7), '0);
        send(0, 0, 1, 0, rep(6'd9), '0);
        #2 rst = 1;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_y", bus.y, 0);
        chk("arst_dz", bus.dz, 0);
        chk("arst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1 rst = 0;
        chk("rst_release_in_ready", bus.in_ready, 1);
        run1(0, 0, 1, 0, rep(6'd3), '0);
        chk("acc_after_rst", ry[W-1:0], 3);

        done = 0;
        fork
            begin
                for (int n = 0; n < 20000 && !done; n++) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 9) < 7);
                end
            end
            begin
                for (int t = 0; t < 250; t++) begin
                    o = 3'($urandom_range(0, 7));
                    av = LW'($urandom);
                    bv = LW'($urandom);
                    if (o == 3'd5 || o == 3'd6)
                        for (int l = 0; l < LANES; l++) bv[l*W +: W] = W'($urandom_range(0, W + 3));
                    if ($urandom_range(0, 3) == 0) bv[$urandom_range(0, LANES - 1) * W +: W] = '0;
                    send(o, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
                         $urandom_range(0, 9) == 0, av, bv);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1;
            end
        join
        bus.out_ready = 1;
        repeat (10) @(negedge clk);
        chk("drain_empty", qy.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
